// File: rtl/inst_mem_responder_pkg.sv
// Shared widths, defaults and state encoding for the instruction-memory responder.
// Also holds the byte-address to word-index helper used by fetch and boot-load paths.
package inst_mem_responder_pkg;

  localparam int          INST_ADDR_W       = 32;
  localparam int          INST_W            = 32;
  localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
  localparam int          INST_MEM_NUM_LOG2 = 17;
  localparam int          WAIT_W            = 4;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Callers truncate the result to the RAM index width, so high bits wrap.
  function automatic logic [INST_ADDR_W-1:0] word_of(input logic [INST_ADDR_W-1:0] a);
    return a >> 2;
  endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch (ce/addr -> inst) and boot-load (valid/ready) signals between CPU/loader and responder.
// The responder uses the slave modport; CPU and loader drive through master.
interface inst_mem_responder_if;
  import inst_mem_responder_pkg::*;

  logic                   ce;
  logic [INST_ADDR_W-1:0] addr;
  logic [INST_W-1:0]      inst;
  logic                   inst_valid;
  logic                   stall_req;
  logic                   load_valid;
  logic                   load_ready;
  logic [INST_ADDR_W-1:0] load_addr;
  logic [INST_W-1:0]      load_data;
  logic                   load_last;
  logic                   boot_done;

  modport slave (
    input  ce, addr, load_valid, load_addr, load_data, load_last,
    output inst, inst_valid, stall_req, load_ready, boot_done
  );

  modport master (
    output ce, addr, load_valid, load_addr, load_data, load_last,
    input  inst, inst_valid, stall_req, load_ready, boot_done
  );

endinterface

// File: rtl/inst_ram_sp.sv
// Single-port synchronous RAM: write on we, registered read data updated only on re.
// rdata holds between reads and resets to zero; array contents are never cleared.
module inst_ram_sp #(
  parameter int AW = 17,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction RAM responder: boot-loads, then serves fetches WAIT_STATES+1 cycles after request.
// stall_req holds the pipeline during load and fetch; load_ready is high only while loading.
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH_LOG2 = INST_MEM_NUM_LOG2,
  parameter int WAIT_STATES    = 1
) (
  input logic                  clk,
  input logic                  rst,
  inst_mem_responder_if.slave  bus
);

  state_e                    state_d, state_q;
  logic [WAIT_W-1:0]         cnt_d, cnt_q;
  logic [MEM_DEPTH_LOG2-1:0] addr_d, addr_q;
  logic                      inst_valid_d, inst_valid_q;
  logic                      boot_done_d, boot_done_q;

  logic                      ram_we, ram_re;
  logic [MEM_DEPTH_LOG2-1:0] ram_idx, fetch_idx, load_idx;
  logic                      stall_req, load_ready;

  assign fetch_idx = MEM_DEPTH_LOG2'(word_of(bus.addr));
  assign load_idx  = MEM_DEPTH_LOG2'(word_of(bus.load_addr));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    inst_valid_d = 1'b0;
    boot_done_d  = boot_done_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_idx      = addr_q;
    stall_req    = 1'b0;
    load_ready   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load_ready = 1'b1;
        stall_req  = 1'b1;
        ram_idx    = load_idx;
        if (bus.load_valid) begin
          ram_we = 1'b1;
          if (bus.load_last) begin
            state_d     = ST_IDLE;
            boot_done_d = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        stall_req = bus.ce;
        ram_idx   = fetch_idx;
        if (bus.ce) begin
          addr_d = fetch_idx;
          cnt_d  = WAIT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            ram_re       = 1'b1;
            state_d      = ST_RESP;
            inst_valid_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall_req = 1'b1;
        // A dropped ce wins over a read that would otherwise happen this edge.
        if (!bus.ce) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
          if (cnt_q == WAIT_W'(1)) begin
            ram_re       = 1'b1;
            state_d      = ST_RESP;
            inst_valid_d = 1'b1;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_LOAD;
      cnt_q        <= '0;
      addr_q       <= '0;
      inst_valid_q <= 1'b0;
      boot_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      inst_valid_q <= inst_valid_d;
      boot_done_q  <= boot_done_d;
    end
  end

  // The RAM's registered read port is the inst register itself.
  inst_ram_sp #(
    .AW(MEM_DEPTH_LOG2),
    .DW(INST_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .idx  (ram_idx),
    .wdata(bus.load_data),
    .rdata(bus.inst)
  );

  assign bus.inst_valid = inst_valid_q;
  assign bus.boot_done  = boot_done_q;
  assign bus.stall_req  = stall_req;
  assign bus.load_ready = load_ready;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench: three responders (WAIT_STATES 1/0/3, 16-word RAM) share reset and boot-load.
// Each has its own fetch port; expected values are hand-computed constants.
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_vld = 1'b0;
  logic        ld_last = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_dat = '0;
  logic        ce1 = 1'b0, ce0 = 1'b0, ce3 = 1'b0;
  logic [31:0] addr1 = '0, addr0 = '0, addr3 = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] boot_words [4];

  always #5 clk = ~clk;

  inst_mem_responder_if b1();
  inst_mem_responder_if b0();
  inst_mem_responder_if b3();

  assign b1.ce = ce1;  assign b1.addr = addr1;
  assign b0.ce = ce0;  assign b0.addr = addr0;
  assign b3.ce = ce3;  assign b3.addr = addr3;
  assign b1.load_valid = ld_vld;  assign b1.load_addr = ld_addr;
  assign b1.load_data  = ld_dat;  assign b1.load_last = ld_last;
  assign b0.load_valid = ld_vld;  assign b0.load_addr = ld_addr;
  assign b0.load_data  = ld_dat;  assign b0.load_last = ld_last;
  assign b3.load_valid = ld_vld;  assign b3.load_addr = ld_addr;
  assign b3.load_data  = ld_dat;  assign b3.load_last = ld_last;

  inst_mem_responder #(.MEM_DEPTH_LOG2(4), .WAIT_STATES(1)) u_ws1 (.clk(clk), .rst(rst), .bus(b1));
  inst_mem_responder #(.MEM_DEPTH_LOG2(4), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst), .bus(b0));
  inst_mem_responder #(.MEM_DEPTH_LOG2(4), .WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    boot_words[0] = 32'h3401_1100;
    boot_words[1] = 32'h3402_0020;
    boot_words[2] = 32'h3403_ff00;
    boot_words[3] = 32'h3404_ffff;

    // Reset held for three cycles
    repeat (3) tick();
    chk("rst_inst", b1.inst, 32'h0);
    chk("rst_inst_valid", {31'b0, b1.inst_valid}, 32'h0);
    chk("rst_boot_done", {31'b0, b1.boot_done}, 32'h0);
    chk("rst_load_ready", {31'b0, b1.load_ready}, 32'h1);
    chk("rst_stall", {31'b0, b1.stall_req}, 32'h1);
    rst = 1'b1;

    // Boot load of four words, last one flagged
    for (int i = 0; i < 4; i++) begin
      ld_vld  = 1'b1;
      ld_addr = 32'(i * 4);
      ld_dat  = boot_words[i];
      ld_last = (i == 3);
      #1;
      chk("load_stall", {31'b0, b1.stall_req}, 32'h1);
      chk("load_ready", {31'b0, b3.load_ready}, 32'h1);
      chk("load_boot_done_low", {31'b0, b0.boot_done}, 32'h0);
      tick();
    end
    ld_vld  = 1'b0;
    ld_last = 1'b0;
    #1;
    chk("boot_done_ws1", {31'b0, b1.boot_done}, 32'h1);
    chk("boot_done_ws3", {31'b0, b3.boot_done}, 32'h1);
    chk("idle_load_ready", {31'b0, b1.load_ready}, 32'h0);
    chk("idle_stall", {31'b0, b1.stall_req}, 32'h0);
    chk("inst_before_fetch", b1.inst, 32'h0);

    // WAIT_STATES=1 fetch of 0x4
    ce1 = 1'b1; addr1 = 32'h4;
    #1;
    chk("ws1_req_stall", {31'b0, b1.stall_req}, 32'h1);
    tick();
    chk("ws1_wait_stall", {31'b0, b1.stall_req}, 32'h1);
    chk("ws1_wait_valid", {31'b0, b1.inst_valid}, 32'h0);
    tick();
    chk("ws1_resp_valid", {31'b0, b1.inst_valid}, 32'h1);
    chk("ws1_resp_inst", b1.inst, 32'h3402_0020);
    chk("ws1_resp_stall", {31'b0, b1.stall_req}, 32'h0);
    ce1 = 1'b0;
    tick();
    chk("ws1_after_valid", {31'b0, b1.inst_valid}, 32'h0);
    chk("ws1_after_inst", b1.inst, 32'h3402_0020);

    // WAIT_STATES=0 back-to-back fetches of 0x0 then 0x8
    ce0 = 1'b1; addr0 = 32'h0;
    #1;
    chk("ws0_req_stall", {31'b0, b0.stall_req}, 32'h1);
    tick();
    chk("ws0_resp1_valid", {31'b0, b0.inst_valid}, 32'h1);
    chk("ws0_resp1_inst", b0.inst, 32'h3401_1100);
    chk("ws0_resp1_stall", {31'b0, b0.stall_req}, 32'h0);
    addr0 = 32'h8;
    tick();
    chk("ws0_req2_valid", {31'b0, b0.inst_valid}, 32'h0);
    chk("ws0_req2_stall", {31'b0, b0.stall_req}, 32'h1);
    tick();
    chk("ws0_resp2_valid", {31'b0, b0.inst_valid}, 32'h1);
    chk("ws0_resp2_inst", b0.inst, 32'h3403_ff00);
    ce0 = 1'b0;
    tick();
    chk("ws0_after_valid", {31'b0, b0.inst_valid}, 32'h0);

    // WAIT_STATES=3: full fetch of 0xC, then an aborted fetch of 0x4
    ce3 = 1'b1; addr3 = 32'hC;
    repeat (3) begin
      tick();
      chk("ws3_wait_valid", {31'b0, b3.inst_valid}, 32'h0);
      chk("ws3_wait_stall", {31'b0, b3.stall_req}, 32'h1);
    end
    tick();
    chk("ws3_resp_valid", {31'b0, b3.inst_valid}, 32'h1);
    chk("ws3_resp_inst", b3.inst, 32'h3404_ffff);
    ce3 = 1'b0;
    tick();
    ce3 = 1'b1; addr3 = 32'h4;
    tick();
    tick();
    ce3 = 1'b0;
    #1;
    chk("abort_wait_stall", {31'b0, b3.stall_req}, 32'h1);
    tick();
    chk("abort_idle_stall", {31'b0, b3.stall_req}, 32'h0);
    chk("abort_load_ready", {31'b0, b3.load_ready}, 32'h0);
    repeat (3) begin
      chk("abort_no_valid", {31'b0, b3.inst_valid}, 32'h0);
      chk("abort_inst_held", b3.inst, 32'h3404_ffff);
      tick();
    end

    // Wrap and misalignment: 0x43 maps to index 0 in a 16-word RAM
    ce1 = 1'b1; addr1 = 32'h43;
    tick();
    tick();
    chk("wrap_valid", {31'b0, b1.inst_valid}, 32'h1);
    chk("wrap_inst", b1.inst, 32'h3401_1100);
    ce1 = 1'b0;
    tick();

    // Reset asserted mid-WAIT takes effect without a clock edge
    ce3 = 1'b1; addr3 = 32'h0;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, b3.inst_valid}, 32'h0);
    chk("mid_rst_inst", b3.inst, 32'h0);
    chk("mid_rst_boot_done", {31'b0, b3.boot_done}, 32'h0);
    chk("mid_rst_load_ready", {31'b0, b3.load_ready}, 32'h1);
    ce3 = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // Reload only the final word; earlier words must survive
    ld_vld = 1'b1; ld_addr = 32'hC; ld_dat = 32'hDEAD_BEEF; ld_last = 1'b1;
    tick();
    ld_vld = 1'b0; ld_last = 1'b0;
    #1;
    chk("reload_boot_done", {31'b0, b3.boot_done}, 32'h1);
    ce3 = 1'b1; addr3 = 32'h4;
    repeat (4) tick();
    chk("reload_old_valid", {31'b0, b3.inst_valid}, 32'h1);
    chk("reload_old_inst", b3.inst, 32'h3402_0020);
    ce3 = 1'b0;
    tick();
    ce3 = 1'b1; addr3 = 32'hC;
    repeat (4) tick();
    chk("reload_new_valid", {31'b0, b3.inst_valid}, 32'h1);
    chk("reload_new_inst", b3.inst, 32'hDEAD_BEEF);
    ce3 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
